// File: rtl/mips_defs.sv
// Shared decode constants, forwarding codes and scoreboard types for the
// 5-stage MIPS hazard logic.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   localparam logic [2:0] FWD_D_RD1   = 3'd0;
   localparam logic [2:0] FWD_D_PC8_E = 3'd1;
   localparam logic [2:0] FWD_D_ALU_M = 3'd2;
   localparam logic [2:0] FWD_D_PC8_M = 3'd3;

   localparam logic [2:0] FWD_E_REG   = 3'd0;
   localparam logic [2:0] FWD_E_ALU_M = 3'd1;
   localparam logic [2:0] FWD_E_PC8_M = 3'd2;
   localparam logic [2:0] FWD_E_WD_W  = 3'd3;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MEM = 2'd1,
      SRC_PC8 = 2'd2
   } src_t;

   localparam logic [1:0] TUSE_BR  = 2'd0;
   localparam logic [1:0] TUSE_ALU = 2'd1;
   localparam logic [1:0] TUSE_ST  = 2'd2;

   localparam logic [1:0] TNEW_PC8 = 2'd0;
   localparam logic [1:0] TNEW_ALU = 2'd1;
   localparam logic [1:0] TNEW_MEM = 2'd2;

   localparam logic [4:0] REG_RA = 5'd31;

   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
      src_t       src;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       is_md_start;
   } e_stage_t;

   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
      src_t       src;
   } m_stage_t;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // $0 is hard-wired, so a zero destination never produces a hazard.
   function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
      return (a3 != 5'd0) && (a3 == r);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage instruction in, stall / forward / mult-div controls out.
interface hazard_ctrl_if;
   logic [31:0] Instr_D;
   logic        Stall;
   logic [2:0]  ForwardRSD;
   logic [2:0]  ForwardRTD;
   logic [2:0]  ForwardRSE;
   logic [2:0]  ForwardRTE;
   logic        MD_Start;
   logic        MD_Busy;

   modport master (
      output Instr_D,
      input  Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, MD_Start, MD_Busy
   );

   modport slave (
      input  Instr_D,
      output Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, MD_Start, MD_Busy
   );
endinterface

// File: rtl/hazard_ctrl_instr_classifier.sv
// Combinational decode of one instruction into its source/destination
// timing (Tuse/Tnew) and mult/div attributes; unsupported encodings act as nop.
module instr_classifier
   import mips_defs::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic [31:0]      Instr,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic             rs_used,
   output logic             rt_used,
   output logic [1:0]       tuse_rs,
   output logic [1:0]       tuse_rt,
   output logic [4:0]       a3,
   output logic [1:0]       tnew,
   output src_t             src,
   output logic             is_md,
   output logic             is_md_start,
   output logic [CNT_W-1:0] md_cycles
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rd;
   logic [4:0] shamt;

   assign op    = Instr[31:26];
   assign rs    = Instr[25:21];
   assign rt    = Instr[20:16];
   assign rd    = Instr[15:11];
   assign shamt = Instr[10:6];
   assign funct = Instr[5:0];

   always_comb begin
      rs_used     = 1'b0;
      rt_used     = 1'b0;
      tuse_rs     = TUSE_BR;
      tuse_rt     = TUSE_BR;
      a3          = 5'd0;
      tnew        = 2'd0;
      src         = SRC_ALU;
      is_md       = 1'b0;
      is_md_start = 1'b0;
      md_cycles   = '0;
      case (op)
         // R-type encodings with a nonzero shift field are not in the
         // supported set, so they fall through as nop.
         OP_RTYPE: if (shamt == 5'd0) begin
            case (funct)
               FN_ADDU, FN_SUBU: begin
                  rs_used = 1'b1;
                  rt_used = 1'b1;
                  tuse_rs = TUSE_ALU;
                  tuse_rt = TUSE_ALU;
                  a3      = rd;
                  tnew    = TNEW_ALU;
               end
               FN_JR: begin
                  rs_used = 1'b1;
                  tuse_rs = TUSE_BR;
               end
               FN_MULT, FN_MULTU: begin
                  rs_used     = 1'b1;
                  rt_used     = 1'b1;
                  tuse_rs     = TUSE_ALU;
                  tuse_rt     = TUSE_ALU;
                  is_md       = 1'b1;
                  is_md_start = 1'b1;
                  md_cycles   = CNT_W'(MULT_CYCLES);
               end
               FN_DIV, FN_DIVU: begin
                  rs_used     = 1'b1;
                  rt_used     = 1'b1;
                  tuse_rs     = TUSE_ALU;
                  tuse_rt     = TUSE_ALU;
                  is_md       = 1'b1;
                  is_md_start = 1'b1;
                  md_cycles   = CNT_W'(DIV_CYCLES);
               end
               FN_MFHI, FN_MFLO: begin
                  a3    = rd;
                  tnew  = TNEW_ALU;
                  is_md = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  rs_used = 1'b1;
                  tuse_rs = TUSE_ALU;
                  is_md   = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ORI, OP_LUI: begin
            rs_used = 1'b1;
            tuse_rs = TUSE_ALU;
            a3      = rt;
            tnew    = TNEW_ALU;
         end
         OP_LW: begin
            rs_used = 1'b1;
            tuse_rs = TUSE_ALU;
            a3      = rt;
            tnew    = TNEW_MEM;
            src     = SRC_MEM;
         end
         OP_SW: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            tuse_rs = TUSE_ALU;
            tuse_rt = TUSE_ST;
         end
         OP_BEQ: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            tuse_rs = TUSE_BR;
            tuse_rt = TUSE_BR;
         end
         OP_JAL: begin
            a3   = REG_RA;
            tnew = TNEW_PC8;
            src  = SRC_PC8;
         end
         OP_J: ;
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: registered E/M/W destination scoreboard, stall and
// forward-select generation, and mult/div busy sequencing.
module hazard_ctrl
   import mips_defs::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);

   localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W  = $clog2(MD_MAX + 1);

   logic [4:0]       d_rs, d_rt, d_a3;
   logic             d_rs_used, d_rt_used;
   logic [1:0]       d_tuse_rs, d_tuse_rt, d_tnew;
   src_t             d_src;
   logic             d_is_md, d_is_md_start;
   logic [CNT_W-1:0] d_md_cycles;

   e_stage_t         e_q, e_next;
   logic [CNT_W-1:0] e_md_cycles;
   m_stage_t         m_q;
   logic [4:0]       w_a3;
   logic [CNT_W-1:0] md_cnt;

   logic rs_hazard, rt_hazard, md_start, md_busy, stall;

   instr_classifier #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_classifier (
      .Instr       (hz.Instr_D),
      .rs          (d_rs),
      .rt          (d_rt),
      .rs_used     (d_rs_used),
      .rt_used     (d_rt_used),
      .tuse_rs     (d_tuse_rs),
      .tuse_rt     (d_tuse_rt),
      .a3          (d_a3),
      .tnew        (d_tnew),
      .src         (d_src),
      .is_md       (d_is_md),
      .is_md_start (d_is_md_start),
      .md_cycles   (d_md_cycles)
   );

   // A newer E match shadows M even when it cannot forward yet.
   function automatic logic [2:0] fwd_d_sel(input e_stage_t e, input m_stage_t m,
                                            input logic [4:0] r);
      if (reg_match(e.a3, r))
         return (e.tnew == 2'd0 && e.src == SRC_PC8) ? FWD_D_PC8_E : FWD_D_RD1;
      if (reg_match(m.a3, r) && m.tnew == 2'd0) begin
         if (m.src == SRC_PC8) return FWD_D_PC8_M;
         if (m.src == SRC_ALU) return FWD_D_ALU_M;
      end
      return FWD_D_RD1;
   endfunction

   function automatic logic [2:0] fwd_e_sel(input m_stage_t m, input logic [4:0] w,
                                            input logic [4:0] r);
      if (reg_match(m.a3, r)) begin
         if (m.tnew == 2'd0 && m.src == SRC_PC8) return FWD_E_PC8_M;
         if (m.tnew == 2'd0 && m.src == SRC_ALU) return FWD_E_ALU_M;
         return FWD_E_REG;
      end
      if (reg_match(w, r)) return FWD_E_WD_W;
      return FWD_E_REG;
   endfunction

   assign e_next = '{a3: d_a3, tnew: d_tnew, src: d_src, rs: d_rs, rt: d_rt,
                     is_md_start: d_is_md_start};

   always_comb begin
      rs_hazard = d_rs_used &&
                  ((reg_match(e_q.a3, d_rs) && (e_q.tnew > d_tuse_rs)) ||
                   (reg_match(m_q.a3, d_rs) && (m_q.tnew > d_tuse_rs)));
      rt_hazard = d_rt_used &&
                  ((reg_match(e_q.a3, d_rt) && (e_q.tnew > d_tuse_rt)) ||
                   (reg_match(m_q.a3, d_rt) && (m_q.tnew > d_tuse_rt)));
   end

   assign md_start = e_q.is_md_start;
   assign md_busy  = (md_cnt != '0);
   assign stall    = rs_hazard || rt_hazard || (d_is_md && (md_start || md_busy));

   assign hz.Stall      = stall;
   assign hz.MD_Start   = md_start;
   assign hz.MD_Busy    = md_busy;
   assign hz.ForwardRSD = fwd_d_sel(e_q, m_q, d_rs);
   assign hz.ForwardRTD = fwd_d_sel(e_q, m_q, d_rt);
   assign hz.ForwardRSE = fwd_e_sel(m_q, w_a3, e_q.rs);
   assign hz.ForwardRTE = fwd_e_sel(m_q, w_a3, e_q.rt);

   // The stall bubble is an all-zero entry, so it can neither be a
   // forwarding source nor read stale rs/rt in EX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q         <= '0;
         e_md_cycles <= '0;
         m_q         <= '0;
         w_a3        <= '0;
         md_cnt      <= '0;
      end else begin
         if (stall) begin
            e_q         <= '0;
            e_md_cycles <= '0;
         end else begin
            e_q         <= e_next;
            e_md_cycles <= d_md_cycles;
         end
         m_q  <= '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew), src: e_q.src};
         w_a3 <= m_q.a3;
         if (md_start)
            md_cnt <= e_md_cycles;
         else if (md_busy)
            md_cnt <= md_cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed test-plan scenarios plus a randomized instruction stream checked
// against an instruction-level pipeline model.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

   hazard_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   typedef enum int {
      K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR,
      K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_BAD_OP, K_BAD_FN
   } kind_e;

   typedef struct {
      kind_e       k;
      logic [4:0]  rs, rt, rd;
      logic [25:0] imm;
   } ins_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(input kind_e k, input int rs, input int rt, input int rd);
      ins_t i;
      i.k = k; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.imm = '0;
      return i;
   endfunction

   function automatic logic [31:0] rtype(input ins_t i, input logic [5:0] fn);
      return {6'h00, i.rs, i.rt, i.rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input ins_t i, input logic [5:0] op);
      return {op, i.rs, i.rt, i.imm[15:0]};
   endfunction

   function automatic logic [31:0] enc(input ins_t i);
      case (i.k)
         K_ADDU:   return rtype(i, 6'h21);
         K_SUBU:   return rtype(i, 6'h23);
         K_JR:     return rtype(i, 6'h08);
         K_MULT:   return rtype(i, 6'h18);
         K_MULTU:  return rtype(i, 6'h19);
         K_DIV:    return rtype(i, 6'h1a);
         K_DIVU:   return rtype(i, 6'h1b);
         K_MFHI:   return rtype(i, 6'h10);
         K_MTHI:   return rtype(i, 6'h11);
         K_MFLO:   return rtype(i, 6'h12);
         K_MTLO:   return rtype(i, 6'h13);
         K_BAD_FN: return rtype(i, 6'h20);
         K_ORI:    return itype(i, 6'h0d);
         K_LUI:    return itype(i, 6'h0f);
         K_LW:     return itype(i, 6'h23);
         K_SW:     return itype(i, 6'h2b);
         K_BEQ:    return itype(i, 6'h04);
         K_BAD_OP: return itype(i, 6'h08);
         K_J:      return {6'h02, i.imm};
         K_JAL:    return {6'h03, i.imm};
         default:  return 32'h0;
      endcase
   endfunction

   // Instruction-level properties taken from the Tuse/Tnew tables.
   function automatic int dest(input ins_t i);
      case (i.k)
         K_ADDU, K_SUBU, K_MFHI, K_MFLO: return int'(i.rd);
         K_ORI, K_LUI, K_LW:             return int'(i.rt);
         K_JAL:                          return 31;
         default:                        return 0;
      endcase
   endfunction

   function automatic int tnew_at_e(input kind_e k);
      case (k)
         K_LW:   return 2;
         K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_pc8(input kind_e k);
      return k == K_JAL;
   endfunction

   function automatic int tuse_rs(input kind_e k);
      case (k)
         K_BEQ, K_JR: return 0;
         K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU,
         K_ORI, K_LUI, K_LW, K_SW, K_MTHI, K_MTLO: return 1;
         default: return -1;
      endcase
   endfunction

   function automatic int tuse_rt(input kind_e k);
      case (k)
         K_BEQ: return 0;
         K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU: return 1;
         K_SW:  return 2;
         default: return -1;
      endcase
   endfunction

   function automatic bit is_md(input kind_e k);
      return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO};
   endfunction

   function automatic int md_len(input kind_e k);
      if (k inside {K_MULT, K_MULTU}) return 5;
      if (k inside {K_DIV, K_DIVU})   return 10;
      return 0;
   endfunction

   function automatic bit hit(input ins_t i, input int r);
      return dest(i) != 0 && dest(i) == r;
   endfunction

   function automatic int rem_m(input ins_t m);
      return (tnew_at_e(m.k) > 0) ? tnew_at_e(m.k) - 1 : 0;
   endfunction

   function automatic bit src_stall(input int tuse, input int r, input ins_t e, input ins_t m);
      if (tuse < 0) return 1'b0;
      return (hit(e, r) && tnew_at_e(e.k) > tuse) || (hit(m, r) && rem_m(m) > tuse);
   endfunction

   function automatic int exp_fwd_d(input ins_t e, input ins_t m, input int r);
      if (hit(e, r)) return (tnew_at_e(e.k) == 0 && is_pc8(e.k)) ? 1 : 0;
      if (hit(m, r) && rem_m(m) == 0) return is_pc8(m.k) ? 3 : (m.k == K_LW ? 0 : 2);
      return 0;
   endfunction

   function automatic int exp_fwd_e(input ins_t m, input ins_t w, input int r);
      if (hit(m, r)) return (rem_m(m) == 0) ? (is_pc8(m.k) ? 2 : (m.k == K_LW ? 0 : 1)) : 0;
      if (hit(w, r)) return 3;
      return 0;
   endfunction

   function automatic logic [4:0] rand_reg();
      case ($urandom_range(0, 4))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         3: return 5'd3;
         default: return 5'd31;
      endcase
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      i.k   = kind_e'($urandom_range(0, int'(K_BAD_FN)));
      i.rs  = rand_reg();
      i.rt  = rand_reg();
      i.rd  = rand_reg();
      i.imm = 26'($urandom);
      return i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input ins_t i);
      hz.Instr_D = enc(i);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stall"}, hz.Stall, 0);
      check_eq({tag, "_mdstart"}, hz.MD_Start, 0);
      check_eq({tag, "_mdbusy"}, hz.MD_Busy, 0);
      check_eq({tag, "_frsd"}, hz.ForwardRSD, 0);
      check_eq({tag, "_frtd"}, hz.ForwardRTD, 0);
      check_eq({tag, "_frse"}, hz.ForwardRSE, 0);
      check_eq({tag, "_frte"}, hz.ForwardRTE, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hz.Instr_D = $urandom;
      @(negedge clk);
      check_all_zero("rst");
      tick();
      reset = 1'b0;
      set_d(mk(K_NOP, 0, 0, 0));
   endtask

   task automatic md_run(input kind_e k, input string tag, input int exp_stall, input int exp_busy);
      int n_st, n_start, n_busy;
      logic st;
      n_st = 0; n_start = 0; n_busy = 0;
      do_reset();
      set_d(mk(k, 4, 5, 0));
      tick();
      set_d(mk(K_MFLO, 0, 0, 6));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         st = hz.Stall;
         n_st    += int'(st);
         n_start += int'(hz.MD_Start);
         n_busy  += int'(hz.MD_Busy);
         tick();
         if (!st) set_d(mk(K_NOP, 0, 0, 0));
      end
      check_eq({tag, "_stall_cycles"}, n_st, exp_stall);
      check_eq({tag, "_start_cycles"}, n_start, 1);
      check_eq({tag, "_busy_cycles"}, n_busy, exp_busy);
   endtask

   ins_t d, me, mm, mw;
   int   cyc, busy_until;

   initial begin
      reset = 1'b1;
      hz.Instr_D = '0;

      // Load-use: one stall cycle, then W-stage forward in EX.
      do_reset();
      set_d(mk(K_LW, 1, 8, 0));
      tick();
      set_d(mk(K_ADDU, 8, 1, 9));
      @(negedge clk); check_eq("lw_use_stall", hz.Stall, 1);
      tick();
      @(negedge clk); check_eq("lw_use_release", hz.Stall, 0);
      check_eq("lw_use_frsd", hz.ForwardRSD, 0);
      tick();
      set_d(mk(K_NOP, 0, 0, 0));
      @(negedge clk); check_eq("lw_use_frse", hz.ForwardRSE, 3);
      check_eq("lw_use_frte", hz.ForwardRTE, 0);

      // jal then jr $31 from E and from M.
      do_reset();
      set_d(mk(K_JAL, 0, 0, 0));
      tick();
      set_d(mk(K_JR, 31, 0, 0));
      @(negedge clk); check_eq("jal_e_stall", hz.Stall, 0);
      check_eq("jal_e_frsd", hz.ForwardRSD, 1);
      tick();
      @(negedge clk); check_eq("jal_m_frsd", hz.ForwardRSD, 3);
      check_eq("jal_m_stall", hz.Stall, 0);

      // ALU result feeding a branch.
      do_reset();
      set_d(mk(K_ADDU, 1, 2, 3));
      tick();
      set_d(mk(K_BEQ, 3, 0, 0));
      @(negedge clk); check_eq("alu_br_stall", hz.Stall, 1);
      tick();
      @(negedge clk); check_eq("alu_br_release", hz.Stall, 0);
      check_eq("alu_br_frsd", hz.ForwardRSD, 2);
      check_eq("alu_br_frtd", hz.ForwardRTD, 0);

      md_run(K_MULT, "mult", 6, 5);
      md_run(K_DIV, "div", 11, 10);

      // Writes to $0 never create hazards.
      do_reset();
      set_d(mk(K_ADDU, 1, 2, 0));
      tick();
      set_d(mk(K_BEQ, 0, 0, 0));
      @(negedge clk); check_eq("zero_stall", hz.Stall, 0);
      check_eq("zero_frsd", hz.ForwardRSD, 0);
      check_eq("zero_frtd", hz.ForwardRTD, 0);

      // Asynchronous reset with a divide in flight.
      do_reset();
      set_d(mk(K_DIV, 4, 5, 0));
      tick();
      set_d(mk(K_NOP, 0, 0, 0));
      for (int c = 0; c < 4; c++) tick();
      set_d(mk(K_MFLO, 0, 0, 6));
      #1;
      check_eq("async_pre_busy", hz.MD_Busy, 1);
      check_eq("async_pre_stall", hz.Stall, 1);
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      #1;
      reset = 1'b0;
      #1;
      check_eq("async_post_busy", hz.MD_Busy, 0);

      // Randomized stream against the instruction-level model.
      do_reset();
      me = mk(K_NOP, 0, 0, 0); mm = me; mw = me;
      cyc = 0; busy_until = 0;
      d = rand_ins();
      set_d(d);
      for (int c = 0; c < 500; c++) begin
         logic [31:0] dw, ew;
         bit   e_start, e_busy, e_stall;
         @(negedge clk);
         dw = enc(d);
         ew = enc(me);
         e_start = md_len(me.k) != 0;
         e_busy  = cyc < busy_until;
         e_stall = src_stall(tuse_rs(d.k), int'(dw[25:21]), me, mm) ||
                   src_stall(tuse_rt(d.k), int'(dw[20:16]), me, mm) ||
                   (is_md(d.k) && (e_start || e_busy));
         check_eq("rnd_stall", hz.Stall, 32'(e_stall));
         check_eq("rnd_mdstart", hz.MD_Start, 32'(e_start));
         check_eq("rnd_mdbusy", hz.MD_Busy, 32'(e_busy));
         check_eq("rnd_frsd", hz.ForwardRSD, exp_fwd_d(me, mm, int'(dw[25:21])));
         check_eq("rnd_frtd", hz.ForwardRTD, exp_fwd_d(me, mm, int'(dw[20:16])));
         check_eq("rnd_frse", hz.ForwardRSE, exp_fwd_e(mm, mw, int'(ew[25:21])));
         check_eq("rnd_frte", hz.ForwardRTE, exp_fwd_e(mm, mw, int'(ew[20:16])));
         @(posedge clk);
         if (e_start) busy_until = cyc + 1 + md_len(me.k);
         mw = mm;
         mm = me;
         me = e_stall ? mk(K_NOP, 0, 0, 0) : d;
         cyc++;
         #1;
         if (!e_stall) d = rand_ins();
         set_d(d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
